// File: rtl/vga_frame_monitor_if.sv
// Bundle of VGA stream inputs and per-frame measurement results for vga_frame_monitor.
// master = video source / result reader, slave = the monitor itself.
interface vga_frame_monitor_if;
    logic        PEN;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        FRAME_DONE;
    logic [9:0]  HMEAS;
    logic [9:0]  VMEAS;
    logic [15:0] FRAME_CNT;
    logic        TIMING_ERR;
    logic [31:0] CSUM;

    modport master (
        output PEN, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
        input  FRAME_DONE, HMEAS, VMEAS, FRAME_CNT, TIMING_ERR, CSUM
    );

    modport slave (
        input  PEN, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
        output FRAME_DONE, HMEAS, VMEAS, FRAME_CNT, TIMING_ERR, CSUM
    );
endinterface

// File: rtl/vga_frame_monitor.sv
// Passive VGA timing checker: measures line/frame lengths, flags deviations, checksums the active picture.
// Define MON_CSUM_EN to build the active-picture checksum; otherwise CSUM reads 0.
module vga_frame_monitor #(
    parameter int unsigned HPERIOD = 800,
    parameter int unsigned VPERIOD = 525,
    parameter int unsigned HSTART  = 144,
    parameter int unsigned HACTIVE = 640,
    parameter int unsigned VSTART  = 35,
    parameter int unsigned VACTIVE = 480
) (
    input logic                CLK,
    input logic                RST,
    vga_frame_monitor_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [9:0] HCNT_MAX = 10'd1023;
    localparam logic [9:0] H_PERIOD = 10'(HPERIOD);
    localparam logic [9:0] V_PERIOD = 10'(VPERIOD);

    state_t      r_state;
    state_t      w_stateNext;
    logic        r_q0Hs;
    logic        r_q0Vs;
    logic        r_q1Hs;
    logic        r_q1Vs;
    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic [9:0]  w_hcntInc;
    logic [9:0]  w_vcntInc;
    logic        w_hsFall;
    logic        w_vsFall;
    logic        w_syncLost;
    logic        w_frameEnd;
    logic        w_lineCheck;
    logic        r_lineSeen;
    logic        r_frameDone;
    logic        r_timingErr;
    logic [9:0]  r_hmeas;
    logic [9:0]  r_vmeas;
    logic [15:0] r_frameCnt;

    assign w_hsFall  = r_q1Hs & ~r_q0Hs;
    assign w_vsFall  = r_q1Vs & ~r_q0Vs;
    assign w_hcntInc = r_hcnt + 10'd1;
    assign w_vcntInc = r_vcnt + 10'd1;

    // Sync pipeline resets to the inactive (high) level so no edge is seen straight out of reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_q0Hs <= 1'b1;
            r_q0Vs <= 1'b1;
            r_q1Hs <= 1'b1;
            r_q1Vs <= 1'b1;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (bus.PEN) begin
            r_q0Hs <= bus.VGA_HS;
            r_q0Vs <= bus.VGA_VS;
            r_q1Hs <= r_q0Hs;
            r_q1Vs <= r_q0Vs;
            if (w_hsFall)
                r_hcnt <= '0;
            else if (r_hcnt != HCNT_MAX)
                r_hcnt <= w_hcntInc;
            if (w_vsFall)
                r_vcnt <= '0;
            else if (w_hsFall)
                r_vcnt <= w_vcntInc;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            r_state <= IDLE;
        else
            r_state <= w_stateNext;
    end

    // A saturated line counter means sync was lost; it pre-empts any check in that same cycle.
    always_comb begin
        w_stateNext = r_state;
        w_syncLost  = 1'b0;
        w_frameEnd  = 1'b0;
        w_lineCheck = 1'b0;
        if (bus.PEN) begin
            case (r_state)
                IDLE: begin
                    if (w_vsFall)
                        w_stateNext = RUN;
                end
                RUN: begin
                    if (r_hcnt == HCNT_MAX) begin
                        w_stateNext = IDLE;
                        w_syncLost  = 1'b1;
                    end else begin
                        w_frameEnd  = w_vsFall;
                        w_lineCheck = w_hsFall & r_lineSeen;
                    end
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_frameDone <= 1'b0;
            r_lineSeen  <= 1'b0;
            r_timingErr <= 1'b0;
            r_hmeas     <= '0;
            r_vmeas     <= '0;
            r_frameCnt  <= '0;
        end else begin
            r_frameDone <= w_frameEnd;
            if (bus.PEN) begin
                if (r_state == IDLE)
                    r_lineSeen <= 1'b0;
                else if (w_hsFall)
                    r_lineSeen <= 1'b1;
                if (w_lineCheck) begin
                    r_hmeas <= w_hcntInc;
                    if (w_hcntInc != H_PERIOD)
                        r_timingErr <= 1'b1;
                end
                if (w_frameEnd) begin
                    r_vmeas    <= w_vcntInc;
                    r_frameCnt <= r_frameCnt + 16'd1;
                    if (w_vcntInc != V_PERIOD)
                        r_timingErr <= 1'b1;
                end
                if (w_syncLost)
                    r_timingErr <= 1'b1;
            end
        end
    end

`ifdef MON_CSUM_EN
    localparam logic [9:0] H_LO = 10'(HSTART);
    localparam logic [9:0] H_HI = 10'(HSTART + HACTIVE);
    localparam logic [9:0] V_LO = 10'(VSTART);
    localparam logic [9:0] V_HI = 10'(VSTART + VACTIVE);

    logic [11:0] r_q0Rgb;
    logic [31:0] r_acc;
    logic [31:0] r_csum;
    logic        w_active;
    logic [31:0] w_pix;

    assign w_active = (r_hcnt >= H_LO) && (r_hcnt < H_HI) && (r_vcnt >= V_LO) && (r_vcnt < V_HI);
    assign w_pix    = w_active ? {20'd0, r_q0Rgb} : 32'd0;

    // Accumulator restarts on every VS edge so the first frame after IDLE starts clean.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_q0Rgb <= '0;
            r_acc   <= '0;
            r_csum  <= '0;
        end else if (bus.PEN) begin
            r_q0Rgb <= {bus.VGA_R, bus.VGA_G, bus.VGA_B};
            if (w_frameEnd)
                r_csum <= r_acc + w_pix;
            if (w_vsFall)
                r_acc <= '0;
            else
                r_acc <= r_acc + w_pix;
        end
    end

    assign bus.CSUM = r_csum;
`else
    assign bus.CSUM = 32'h0;
`endif

    assign bus.FRAME_DONE = r_frameDone;
    assign bus.HMEAS      = r_hmeas;
    assign bus.VMEAS      = r_vmeas;
    assign bus.FRAME_CNT  = r_frameCnt;
    assign bus.TIMING_ERR = r_timingErr;
endmodule
